// File: rtl/int_exec_pkg.sv
// Shared definitions for the integer execute stage: opcodes, FSM encoding, widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Optional build macro INT_EXEC_FAST_MUL_EN removes the iterative MUL state.
package int_exec_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RADDR_DEF = 6;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SAR   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_CMPE  = 4'd8;
    localparam logic [3:0] OP_CMPNE = 4'd9;
    localparam logic [3:0] OP_CMPL  = 4'd10;
    localparam logic [3:0] OP_CMPLE = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_MOD   = 4'd14;
    localparam logic [3:0] OP_ILL   = 4'd15;

    localparam logic [31:0] CMP_TRUE  = 32'hFFFF_FFFF;
    localparam logic [31:0] CMP_FALSE = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
`ifndef INT_EXEC_FAST_MUL_EN
        ST_MUL  = 3'd1,
`endif
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/int_muldiv_iter.sv
// Unsigned iterative datapath: 32-step shift-add multiply or restoring divide.
// Latency: 32 clocks after start; 'last' flags the edge performing step 32.
// Backpressure: none; a start pulse always restarts the sequence.
// Ports: start/is_div/a/b load a job; acc = product or remainder, quo = quotient,
// mul_nxt = product after the current step, last/done = final step / finished.
module int_muldiv_iter
    import int_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] mul_nxt,
    output logic            last,
    output logic            done
);
    // acc_q: product / partial remainder; sh_q: shifted multiplicand / dividend
    // turning into quotient; oth_q: multiplier (shifts right) / divisor (static).
    logic [XLEN-1:0] acc_q, sh_q, oth_q;
    logic [4:0]      cnt_q;
    logic            run_q, done_q, div_q;

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_shift, rem_nxt;

    // Trial subtract of divisor from (remainder << 1 | next dividend bit).
    assign trial     = {acc_q, sh_q[XLEN-1]} - {1'b0, oth_q};
    assign rem_shift = {acc_q[XLEN-2:0], sh_q[XLEN-1]};
    assign rem_nxt   = trial[XLEN] ? rem_shift : trial[XLEN-1:0];
    assign mul_nxt   = acc_q + (oth_q[0] ? sh_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sh_q   <= '0;
            oth_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (start) begin
            acc_q  <= '0;
            sh_q   <= a;
            oth_q  <= b;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
            div_q  <= is_div;
        end else if (run_q) begin
            if (div_q) begin
                acc_q <= rem_nxt;
                sh_q  <= {sh_q[XLEN-2:0], ~trial[XLEN]};
            end else begin
                acc_q <= mul_nxt;
                sh_q  <= sh_q << 1;
                oth_q <= oth_q >> 1;
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign acc  = acc_q;
    assign quo  = sh_q;
    assign last = run_q && (cnt_q == 5'd31);
    assign done = done_q;

endmodule

// File: rtl/int_exec_unit.sv
// Integer execute stage: single-cycle ALU plus iterative MUL/DIV/MOD, writes back to regfile.
// Latency: ALU 1 cycle; MUL 33 cycles (1 with INT_EXEC_FAST_MUL_EN); DIV/MOD 34 cycles.
// Backpressure: op_ready drops while a multi-cycle op runs; re-asserts in its writeback cycle.
// Ports: op_valid/op_ready/op_code/op_rd/op_a/op_b issue; wb_we/wb_rw/wb_dw regfile write;
// busy = multi-cycle op in flight; err = pulse on divide-by-zero or illegal opcode.
// Macro INT_EXEC_FAST_MUL_EN: combinational single-cycle MUL instead of the iterative one.
module int_exec_unit
    import int_exec_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [RADDR-1:0] op_rd,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             wb_we,
    output logic [RADDR-1:0] wb_rw,
    output logic [XLEN-1:0]  wb_dw,
    output logic             busy,
    output logic             err
);
    state_t state, state_nxt;

    logic             accept;
    logic [4:0]       shamt;
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  a_mag, b_mag, md_a, md_b;
    logic             md_start, md_is_div, md_last, md_done;
    logic [XLEN-1:0]  md_acc, md_quo, md_mul_nxt;

    logic             wb_we_nxt, err_nxt;
    logic [RADDR-1:0] wb_rw_nxt;
    logic [XLEN-1:0]  wb_dw_nxt;

    // Issue context held for the multi-cycle writeback.
    logic [RADDR-1:0] rd_q;
    logic             is_mod_q, q_neg_q, r_neg_q;

    assign busy     = !((state == ST_IDLE) || (state == ST_WB));
    assign op_ready = !busy;
    assign accept   = op_valid && op_ready;
    assign shamt    = op_b[4:0];

    always_comb begin
        alu_res = '0;
        case (op_code)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SHL:   alu_res = op_a << shamt;
            OP_SAR:   alu_res = $signed(op_a) >>> shamt;
            OP_SHR:   alu_res = op_a >> shamt;
            OP_CMPE:  alu_res = (op_a == op_b) ? CMP_TRUE : CMP_FALSE;
            OP_CMPNE: alu_res = (op_a != op_b) ? CMP_TRUE : CMP_FALSE;
            OP_CMPL:  alu_res = ($signed(op_a) <  $signed(op_b)) ? CMP_TRUE : CMP_FALSE;
            OP_CMPLE: alu_res = ($signed(op_a) <= $signed(op_b)) ? CMP_TRUE : CMP_FALSE;
`ifdef INT_EXEC_FAST_MUL_EN
            OP_MUL:   alu_res = op_a * op_b;
`endif
            default:  alu_res = '0;
        endcase
    end

    // Divide runs on magnitudes; 0x80000000 maps to itself, which is its
    // correct unsigned magnitude. MUL uses raw operands: the low half of the
    // product is the same for signed and unsigned interpretation.
    assign a_mag     = op_a[XLEN-1] ? -op_a : op_a;
    assign b_mag     = op_b[XLEN-1] ? -op_b : op_b;
    assign md_is_div = (op_code != OP_MUL);
    assign md_a      = md_is_div ? a_mag : op_a;
    assign md_b      = md_is_div ? b_mag : op_b;

    int_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (md_start),
        .is_div  (md_is_div),
        .a       (md_a),
        .b       (md_b),
        .acc     (md_acc),
        .quo     (md_quo),
        .mul_nxt (md_mul_nxt),
        .last    (md_last),
        .done    (md_done)
    );

    always_comb begin
        state_nxt = state;
        wb_we_nxt = 1'b0;
        wb_rw_nxt = wb_rw;
        wb_dw_nxt = wb_dw;
        err_nxt   = 1'b0;
        md_start  = 1'b0;
        case (state)
            ST_IDLE, ST_WB: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    case (op_code)
`ifndef INT_EXEC_FAST_MUL_EN
                        OP_MUL: begin
                            state_nxt = ST_MUL;
                            md_start  = 1'b1;
                        end
`endif
                        OP_DIV, OP_MOD: begin
                            if (op_b == '0) begin
                                // No iterations: immediate result with error flag.
                                wb_we_nxt = 1'b1;
                                wb_rw_nxt = op_rd;
                                wb_dw_nxt = (op_code == OP_DIV) ? '0 : op_a;
                                err_nxt   = 1'b1;
                            end else begin
                                state_nxt = ST_DIV;
                                md_start  = 1'b1;
                            end
                        end
                        OP_ILL: err_nxt = 1'b1;
                        default: begin
                            wb_we_nxt = 1'b1;
                            wb_rw_nxt = op_rd;
                            wb_dw_nxt = alu_res;
                        end
                    endcase
                end
            end
`ifndef INT_EXEC_FAST_MUL_EN
            ST_MUL: begin
                // Capture the product produced by the final step on the same edge.
                if (md_last) begin
                    state_nxt = ST_WB;
                    wb_we_nxt = 1'b1;
                    wb_rw_nxt = rd_q;
                    wb_dw_nxt = md_mul_nxt;
                end
            end
`endif
            ST_DIV: begin
                if (md_last) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                if (md_done) begin
                    state_nxt = ST_WB;
                    wb_we_nxt = 1'b1;
                    wb_rw_nxt = rd_q;
                    if (is_mod_q) wb_dw_nxt = r_neg_q ? -md_acc : md_acc;
                    else          wb_dw_nxt = q_neg_q ? -md_quo : md_quo;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            wb_we <= 1'b0;
            wb_rw <= '0;
            wb_dw <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            wb_we <= wb_we_nxt;
            wb_rw <= wb_rw_nxt;
            wb_dw <= wb_dw_nxt;
            err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            is_mod_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else if (md_start) begin
            rd_q     <= op_rd;
            is_mod_q <= (op_code == OP_MOD);
            q_neg_q  <= op_a[XLEN-1] ^ op_b[XLEN-1];
            r_neg_q  <= op_a[XLEN-1];
        end
    end

endmodule

// File: tb/tb_int_exec_unit.sv
// Self-checking bench for int_exec_unit: scoreboard of expected writebacks.
// Latency: n/a.
// Backpressure: issues only while the unit is idle, except the back-to-back case.
module tb_int_exec_unit;
    import int_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [5:0]  op_rd;
    logic [31:0] op_a, op_b;
    logic        wb_we;
    logic [5:0]  wb_rw;
    logic [31:0] wb_dw;
    logic        busy, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [5:0]  rd;
        logic [31:0] dw;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef INT_EXEC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam int MUL_RDY_LOW = 0;
`else
    localparam int MUL_LAT = 33;
    localparam int MUL_RDY_LOW = 32;
`endif

    always #5 clk = ~clk;

    int_exec_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_rd    (op_rd),
        .op_a     (op_a),
        .op_b     (op_b),
        .wb_we    (wb_we),
        .wb_rw    (wb_rw),
        .wb_dw    (wb_dw),
        .busy     (busy),
        .err      (err)
    );

    // Drive one issue, accepted at the following rising edge; operands are
    // scrambled afterwards so the DUT must have captured them.
    task automatic issue(input logic [3:0] op, input logic [5:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; op_code = op; op_rd = rd; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; op_rd = 6'h3F;
    endtask

    // Bounded wait for a writeback; lat = 0 on timeout.
    task automatic wait_wb(output int lat, output int rdy_low);
        lat = 0; rdy_low = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (wb_we) begin lat = n; break; end
            if (!op_ready) rdy_low++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_rd = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({op_ready, wb_we, wb_rw, wb_dw, busy, err} !== {1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got rdy=%b we=%b rw=%0d dw=%h busy=%b err=%b", op_ready, wb_we, wb_rw, wb_dw, busy, err);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        exp_t e; int lat, rl;
        sb.push_back('{rd: 6'd3, dw: 32'd5, lat: 1});
        issue(OP_ADD, 6'd3, 32'd7, 32'hFFFF_FFFE);
        wait_wb(lat, rl);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat || wb_rw !== e.rd || wb_dw !== e.dw || op_ready !== 1'b1 || err !== 1'b0)
            $display("FAIL add: got lat=%0d rw=%0d dw=%h rdy=%b err=%b exp lat=%0d rw=%0d dw=%h", lat, wb_rw, wb_dw, op_ready, err, e.lat, e.rd, e.dw);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wb_we !== 1'b0 || wb_dw !== 32'd5 || wb_rw !== 6'd3)
            $display("FAIL add_hold: got we=%b rw=%0d dw=%h exp we=0 rw=3 dw=5", wb_we, wb_rw, wb_dw);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        sb.push_back('{rd: 6'd2, dw: 32'hF800_0000, lat: 1});
        sb.push_back('{rd: 6'd4, dw: 32'hFFFF_FFFF, lat: 1});
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_SAR; op_rd = 6'd2; op_a = 32'h8000_0000; op_b = 32'd4;
        @(posedge clk); #1;
        op_code = OP_CMPL; op_rd = 6'd4; op_a = 32'hFFFF_FFFF; op_b = 32'd0;
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (wb_we !== 1'b1 || wb_rw !== e.rd || wb_dw !== e.dw || op_ready !== 1'b1)
            $display("FAIL b2b_sar: got we=%b rw=%0d dw=%h rdy=%b exp rw=%0d dw=%h", wb_we, wb_rw, wb_dw, op_ready, e.rd, e.dw);
        else pass_cnt++;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (wb_we !== 1'b1 || wb_rw !== e.rd || wb_dw !== e.dw)
            $display("FAIL b2b_cmpl: got we=%b rw=%0d dw=%h exp rw=%0d dw=%h", wb_we, wb_rw, wb_dw, e.rd, e.dw);
        else pass_cnt++;
    endtask

    task automatic test_mul;
        exp_t e; int lat, rl;
        sb.push_back('{rd: 6'd7, dw: 32'hFFFF_FFEB, lat: MUL_LAT});
        issue(OP_MUL, 6'd7, 32'hFFFF_FFFD, 32'd7);
        wait_wb(lat, rl);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat || wb_rw !== e.rd || wb_dw !== e.dw)
            $display("FAIL mul_result: got lat=%0d rw=%0d dw=%h exp lat=%0d rw=%0d dw=%h", lat, wb_rw, wb_dw, e.lat, e.rd, e.dw);
        else pass_cnt++;
        total_cnt++;
        if (rl !== MUL_RDY_LOW || op_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL mul_handshake: got rdy_low=%0d rdy=%b busy=%b exp rdy_low=%0d rdy=1 busy=0", rl, op_ready, busy, MUL_RDY_LOW);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wb_we !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL mul_single_pulse: got we=%b rdy=%b exp we=0 rdy=1", wb_we, op_ready);
        else pass_cnt++;
    endtask

    task automatic test_div;
        exp_t e; int lat, rl;
        logic [3:0]  ops [4] = '{OP_DIV, OP_MOD, OP_DIV, OP_MOD};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] xs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rd: 6'(8 + i), dw: xs[i], lat: 34});
            issue(ops[i], 6'(8 + i), as[i], bs[i]);
            total_cnt++;
            if (busy !== 1'b1 || op_ready !== 1'b0)
                $display("FAIL div_busy_%0d: got busy=%b rdy=%b exp busy=1 rdy=0", i, busy, op_ready);
            else pass_cnt++;
            wait_wb(lat, rl);
            e = sb.pop_front();
            total_cnt++;
            if (lat !== e.lat || wb_rw !== e.rd || wb_dw !== e.dw || err !== 1'b0 || rl !== 33)
                $display("FAIL div_%0d: got lat=%0d rw=%0d dw=%h err=%b rdy_low=%0d exp lat=%0d rw=%0d dw=%h rdy_low=33", i, lat, wb_rw, wb_dw, err, rl, e.lat, e.rd, e.dw);
            else pass_cnt++;
        end
    endtask

    task automatic test_div0_illegal;
        exp_t e;
        sb.push_back('{rd: 6'd12, dw: 32'd0, lat: 1});
        issue(OP_DIV, 6'd12, 32'd9, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (wb_we !== 1'b1 || wb_rw !== e.rd || wb_dw !== e.dw || err !== 1'b1 || busy !== 1'b0)
            $display("FAIL div0: got we=%b rw=%0d dw=%h err=%b busy=%b exp we=1 rw=%0d dw=%h err=1", wb_we, wb_rw, wb_dw, err, busy, e.rd, e.dw);
        else pass_cnt++;
        sb.push_back('{rd: 6'd13, dw: 32'd9, lat: 1});
        issue(OP_MOD, 6'd13, 32'd9, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (wb_we !== 1'b1 || wb_rw !== e.rd || wb_dw !== e.dw || err !== 1'b1)
            $display("FAIL mod0: got we=%b rw=%0d dw=%h err=%b exp we=1 rw=%0d dw=%h err=1", wb_we, wb_rw, wb_dw, err, e.rd, e.dw);
        else pass_cnt++;
        issue(OP_ILL, 6'd14, 32'd1, 32'd1);
        @(negedge clk);
        total_cnt++;
        if (wb_we !== 1'b0 || err !== 1'b1 || wb_dw !== 32'd9 || wb_rw !== 6'd13)
            $display("FAIL illegal: got we=%b err=%b rw=%0d dw=%h exp we=0 err=1 rw=13 dw=9", wb_we, err, wb_rw, wb_dw);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0)
            $display("FAIL err_pulse: got err=%b exp 0", err);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        exp_t e; int lat, rl, seen;
        issue(OP_DIV, 6'd20, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL abort_pre_busy: got busy=%b exp 1", busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({op_ready, wb_we, wb_rw, wb_dw, busy, err} !== {1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL abort_outputs: got rdy=%b we=%b rw=%0d dw=%h busy=%b err=%b", op_ready, wb_we, wb_rw, wb_dw, busy, err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_we || err || busy) seen++;
        end
        total_cnt++;
        if (seen !== 0)
            $display("FAIL abort_no_wb: got %0d active cycles exp 0", seen);
        else pass_cnt++;
        sb.push_back('{rd: 6'd5, dw: 32'd3, lat: 1});
        issue(OP_ADD, 6'd5, 32'd1, 32'd2);
        wait_wb(lat, rl);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat || wb_rw !== e.rd || wb_dw !== e.dw)
            $display("FAIL post_reset_add: got lat=%0d rw=%0d dw=%h exp lat=%0d rw=%0d dw=%h", lat, wb_rw, wb_dw, e.lat, e.rd, e.dw);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_mul;
        test_div;
        test_div0_illegal;
        test_reset_abort;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/int_exec_unit.md
Name: int_exec_unit

Overview:
- Integer execute stage directly downstream of the 64x32 integer register file.
- Consumes the two read ports (d0/d1) as operands and computes the result.
- Drives the file's write port (rw/dw/we) for writeback.
- Single-cycle ALU ops plus iterative 32-step MUL/DIV/MOD under a small FSM with valid/ready issue handshake.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- RADDR, 6, register index width (64 registers).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  issue request.
- op_ready  out  1  unit can accept an issue this cycle.
- op_code  in  4  operation select (see Behaviour).
- op_rd  in  RADDR  destination register index.
- op_a  in  XLEN  operand A, from register file d0.
- op_b  in  XLEN  operand B, from register file d1.
- wb_we  out  1  register file write enable (one-cycle pulse).
- wb_rw  out  RADDR  register file write index.
- wb_dw  out  XLEN  register file write data.
- busy  out  1  multi-cycle operation in progress.
- err  out  1  one-cycle pulse on divide-by-zero or illegal opcode.

Interface decision: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.

Behaviour:
- Reset values: op_ready=1, wb_we=0, wb_rw=0, wb_dw=0, busy=0, err=0, FSM=IDLE.
- Issue: accept when op_valid && op_ready at rising edge E0. Operands are captured at E0 and need not be held afterwards.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SAR (arithmetic), 7 SHR (logical). Shift amount is op_b[4:0].
  - 8 CMPE, 9 CMPNE, 10 CMPL, 11 CMPLE. Comparisons are signed; result is 0xFFFFFFFF for true, 0 for false.
  - 12 MUL, 13 DIV, 14 MOD, 15 illegal.
- Arithmetic rules: ADD/SUB wrap modulo 2^32. MUL keeps the low 32 bits. DIV truncates toward zero. MOD takes the sign of the dividend.
- Single-cycle ops: wb_we=1 with wb_rw=op_rd and wb_dw=result for exactly the cycle after E0. op_ready stays 1, so back-to-back issue gives one writeback per cycle.
- FSM states: IDLE, MUL, DIV, FIX, WB.
  - IDLE -> MUL on MUL accept; IDLE -> DIV on DIV/MOD accept.
  - MUL: 32 shift-add iterations at E1..E32 -> WB.
  - DIV: restoring division on operand magnitudes at E1..E32 -> FIX.
  - FIX: sign correction at E33 -> WB.
  - WB: wb_we pulse, then return to IDLE.
- Multi-cycle latency (E0 to the cycle wb_we=1): MUL 33 cycles, DIV/MOD 34 cycles.
- Multi-cycle handshake: from the cycle after E0, busy=1 and op_ready=0. In the WB cycle, busy=0, op_ready=1 and wb_we=1, so a new issue may be accepted in that same cycle.
- Divide by zero: no iterations are run. Writeback happens the cycle after E0 with DIV result 0 and MOD result op_a; err pulses in the same cycle.
- Overflow: DIV 0x80000000 / -1 gives 0x80000000; the matching MOD gives 0.
- Illegal opcode 15: accepted, no writeback (wb_we=0), err pulses the cycle after E0.
- wb_we is never asserted for two consecutive cycles from a single issue.
- When wb_we=0, wb_rw/wb_dw hold their last values.
- rst_n asserted mid-operation: immediate abort and all outputs return to reset values. No partial writeback.

Optional Feature:
- Macro: INT_EXEC_FAST_MUL_EN.
- Defined: MUL is a single-cycle combinational 32x32 multiply (low 32 bits). It writes back the cycle after E0 like ADD, and the MUL FSM state is removed.
- Undefined: iterative 33-cycle MUL as above. DIV/MOD are iterative in both builds.

Decomposition:
- Package int_exec_pkg holds:
  - opcode localparams (OP_ADD..OP_MOD, OP_ILL);
  - FSM state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_WB);
  - XLEN/RADDR defaults;
  - true/false compare constants.
- Sub-module int_muldiv_iter holds the unsigned shift-add/restoring-divide datapath: accumulator, shifted operand, 5-bit step counter, done flag.
- The top level owns the FSM, sign pre/post-processing, single-cycle ALU and writeback registers.

Test Plan:
- Reset, then ADD a=7 b=0xFFFFFFFE rd=3 -> next cycle wb_we=1, wb_rw=3, wb_dw=5; op_ready stays 1.
- Back-to-back SAR a=0x80000000 b=4, then CMPL a=-1 b=0 on consecutive cycles -> wb_dw=0xF8000000, then 0xFFFFFFFF, on consecutive cycles.
- MUL a=-3 b=7 -> op_ready=0 for 32 cycles, wb_dw=0xFFFFFFEB exactly 33 cycles after accept; with INT_EXEC_FAST_MUL_EN, 1 cycle.
- DIV a=-7 b=2 -> wb_dw=0xFFFFFFFD at 34 cycles; MOD same operands -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
- DIV a=9 b=0 -> next cycle wb_dw=0, err=1; MOD a=9 b=0 -> wb_dw=9, err=1; opcode 15 -> err=1, wb_we=0.
- Start DIV, drop rst_n at iteration 10 -> outputs immediately at reset values, no wb_we; after release, ADD works normally.
